y86_fetch_seq: RTL and testbench

Multi-cycle fetch sequencer between a byte-wide instruction memory and the y86 core datapath. It reads one instruction byte per memory handshake starting at the core's current PC and sizes the instruction from its icode. It assembles the 48-bit InstrBytes word, then issues a one-cycle step strobe. The core's PC register and register-file write are gated by step, so the single-cycle datapath advances exactly once per fully fetched instruction.

---
 rtl/y86_fetch_seq.sv | 106 ++++++++++
 tb/tb_y86_fetch_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_seq.sv
// Byte-serial instruction fetch sequencer for a single-cycle y86 core.
// Reads one byte per memory handshake, sizes the instruction from its icode and strobes step once per instruction.
module y86_fetch_seq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        run,
  input  logic [31:0] pc,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [47:0] InstrBytes,
  output logic        instr_valid,
  output logic        step,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t      state, state_nxt;
  logic [2:0]  byte_count;
  logic [2:0]  len;
  logic [2:0]  len_cur;
  logic        bad_icode;
  logic        last_byte;

  function automatic logic [2:0] icode_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:        icode_len = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  icode_len = 3'd2;
      4'h7, 4'h8:              icode_len = 3'd5;
      4'h3, 4'h4, 4'h5:        icode_len = 3'd6;
      default:                 icode_len = 3'd0;
    endcase
  endfunction

  // Byte 0 is sized straight off the bus so one-byte instructions finish in a single handshake.
  assign len_cur   = (byte_count == 3'd0) ? icode_len(mem_rdata[7:4]) : len;
  assign bad_icode = (byte_count == 3'd0) && (mem_rdata[7:4] >= 4'hC);
  assign last_byte = (byte_count + 3'd1) == len_cur;
  assign mem_addr  = pc + 32'(byte_count);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH:
        if (mem_ready) begin
          if (bad_icode)      state_nxt = HALTED;
          else if (last_byte) state_nxt = ISSUE;
        end
      ISSUE:
        if (InstrBytes[47:44] == 4'h0) state_nxt = HALTED;
        else if (run)                  state_nxt = FETCH;
        else                           state_nxt = IDLE;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd      = (state == FETCH);
    instr_valid = (state == ISSUE);
    step        = (state == ISSUE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      byte_count <= 3'd0;
      len        <= 3'd0;
      InstrBytes <= 48'd0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        IDLE: byte_count <= 3'd0;
        FETCH:
          if (mem_ready) begin
            for (int k = 0; k < 6; k++)
              if (byte_count == 3'(k)) InstrBytes[47-8*k -: 8] <= mem_rdata;
            if (byte_count == 3'd0) len <= len_cur;
            if (bad_icode) begin
              illegal <= 1'b1;
              halted  <= 1'b1;
            end else if (!last_byte) begin
              byte_count <= byte_count + 3'd1;
            end
          end
        ISSUE: begin
          byte_count <= 3'd0;
          // A halt keeps its bytes visible; anything else clears for the next fetch.
          if (InstrBytes[47:44] == 4'h0) halted <= 1'b1;
          else                           InstrBytes <= 48'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_seq.sv
// Directed bench for y86_fetch_seq with a byte memory and a minimal core PC model.
module tb_y86_fetch_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        run = 1'b0;
  logic [31:0] pc;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [47:0] InstrBytes;
  logic        instr_valid, step, halted, illegal;

  logic [7:0]  mem [256];
  logic        pulse_mode = 1'b0;
  logic        pc_load = 1'b1;
  logic [31:0] pc_init = 32'h0;
  int          cyc = 0;
  int          step_cnt = 0;
  int          wait_cnt = 0;
  logic [31:0] hs_addr [$];

  int total = 0;
  int passed = 0;

  y86_fetch_seq dut (
    .CLK(CLK), .RESET(RESET), .run(run), .pc(pc),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .InstrBytes(InstrBytes), .instr_valid(instr_valid), .step(step),
    .halted(halted), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ready = pulse_mode ? (cyc % 3 == 0) : 1'b1;

  function automatic logic [31:0] model_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       model_len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: model_len = 2;
      4'h7, 4'h8:             model_len = 5;
      default:                model_len = 6;
    endcase
  endfunction

  // Core side: PC advances only on step.
  always @(posedge CLK) begin
    if (pc_load)   pc <= pc_init;
    else if (step) pc <= pc + model_len(InstrBytes[47:44]);
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_rd && mem_ready)  hs_addr.push_back(mem_addr);
    if (mem_rd && !mem_ready) wait_cnt <= wait_cnt + 1;
    if (step)                 step_cnt <= step_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] start);
    run = 1'b0;
    RESET = 1'b1;
    pc_init = start;
    pc_load = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic wait_step(input int max, output int n);
    n = 0;
    while (step !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    if (step !== 1'b1) check("step_timeout", 64'(step), 64'd1);
  endtask

  initial begin
    int n, base, sbase, wbase;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h20; mem[8'h01] = 8'hF3;
    mem[8'h10] = 8'h30; mem[8'h11] = 8'hF0; mem[8'h12] = 8'h78;
    mem[8'h13] = 8'h56; mem[8'h14] = 8'h34; mem[8'h15] = 8'h12;
    mem[8'h20] = 8'h10; mem[8'h21] = 8'h00;
    mem[8'h30] = 8'hE0;
    mem[8'h40] = 8'h70; mem[8'h41] = 8'h11; mem[8'h42] = 8'h22;
    mem[8'h43] = 8'h33; mem[8'h44] = 8'h44; mem[8'h45] = 8'h10;

    // Reset state
    apply_reset(32'h0000_0040);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'h40);
    check("rst_instr", 64'(InstrBytes), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_step", 64'(step), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);

    // Two-byte rrmovl, zero-wait
    apply_reset(32'h0);
    base = hs_addr.size();
    run = 1'b1;
    wait_step(20, n);
    check("rr_cycles", 64'(n), 64'd3);
    check("rr_instr", 64'(InstrBytes), 64'h20F3_0000_0000);
    check("rr_valid", 64'(instr_valid), 64'd1);
    check("rr_hs", 64'(hs_addr.size() - base), 64'd2);
    check("rr_addr0", 64'(hs_addr[base]), 64'h0);
    check("rr_addr1", 64'(hs_addr[base+1]), 64'h1);
    check("rr_halted", 64'(halted), 64'd0);
    run = 1'b0;
    tick();
    check("rr_pc", 64'(pc), 64'h2);
    check("rr_idle_rd", 64'(mem_rd), 64'd0);
    check("rr_clear", 64'(InstrBytes), 64'd0);

    // Six-byte irmovl with mem_ready every third cycle
    apply_reset(32'h10);
    pulse_mode = 1'b1;
    base = hs_addr.size();
    sbase = step_cnt;
    wbase = wait_cnt;
    run = 1'b1;
    wait_step(40, n);
    check("ir_instr", 64'(InstrBytes), 64'h30F0_7856_3412);
    check("ir_hs", 64'(hs_addr.size() - base), 64'd6);
    for (int i = 0; i < 6; i++)
      if (hs_addr.size() > base + i) check("ir_addr", 64'(hs_addr[base+i]), 64'(32'h10 + i));
    check("ir_wait_rd", 64'(wait_cnt > wbase), 64'd1);
    run = 1'b0;
    tick();
    check("ir_steps", 64'(step_cnt - sbase), 64'd1);
    check("ir_pc", 64'(pc), 64'h16);
    pulse_mode = 1'b0;

    // nop then halt
    apply_reset(32'h20);
    sbase = step_cnt;
    run = 1'b1;
    wait_step(20, n);
    check("nop_cycles", 64'(n), 64'd2);
    check("nop_instr", 64'(InstrBytes), 64'h1000_0000_0000);
    tick();
    wait_step(20, n);
    check("halt_cycles", 64'(n), 64'd1);
    check("halt_instr", 64'(InstrBytes), 64'd0);
    tick();
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_illegal", 64'(illegal), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("halt_rd", 64'(mem_rd), 64'd0);
    check("halt_steps", 64'(step_cnt - sbase), 64'd2);
    check("halt_pc", 64'(pc), 64'h22);

    // Illegal icode, then reset out of HALTED
    apply_reset(32'h30);
    sbase = step_cnt;
    run = 1'b1;
    tick();
    check("ill_fetch_rd", 64'(mem_rd), 64'd1);
    tick();
    check("ill_illegal", 64'(illegal), 64'd1);
    check("ill_halted", 64'(halted), 64'd1);
    check("ill_instr", 64'(InstrBytes), 64'hE000_0000_0000);
    for (int i = 0; i < 3; i++) tick();
    check("ill_rd", 64'(mem_rd), 64'd0);
    check("ill_steps", 64'(step_cnt - sbase), 64'd0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run = 1'b0;
    check("hrst_halted", 64'(halted), 64'd0);
    check("hrst_illegal", 64'(illegal), 64'd0);
    check("hrst_instr", 64'(InstrBytes), 64'd0);
    check("hrst_rd", 64'(mem_rd), 64'd0);

    // run dropped mid-jXX, then resumed
    apply_reset(32'h40);
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("jxx_addr3", 64'(mem_addr), 64'h43);
    run = 1'b0;
    wait_step(20, n);
    check("jxx_cycles", 64'(n), 64'd2);
    check("jxx_instr", 64'(InstrBytes), 64'h7011_2233_4400);
    tick();
    check("jxx_pc", 64'(pc), 64'h45);
    tick();
    check("jxx_idle_rd", 64'(mem_rd), 64'd0);
    check("jxx_idle_valid", 64'(instr_valid), 64'd0);
    base = hs_addr.size();
    run = 1'b1;
    wait_step(20, n);
    check("resume_cycles", 64'(n), 64'd2);
    check("resume_instr", 64'(InstrBytes), 64'h1000_0000_0000);
    check("resume_addr", 64'(hs_addr[base]), 64'h45);
    run = 1'b0;
    tick();

    // Reset in the middle of a fetch, then a clean restart
    apply_reset(32'h10);
    run = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("mrst_addr2", 64'(mem_addr), 64'h12);
    RESET = 1'b1;
    tick();
    check("mrst_rd", 64'(mem_rd), 64'd0);
    check("mrst_instr", 64'(InstrBytes), 64'd0);
    check("mrst_addr", 64'(mem_addr), 64'h10);
    check("mrst_step", 64'(step), 64'd0);
    base = hs_addr.size();
    RESET = 1'b0;
    wait_step(30, n);
    check("mrst_cycles", 64'(n), 64'd7);
    check("mrst_first", 64'(hs_addr[base]), 64'h10);
    check("mrst_instr_ok", 64'(InstrBytes), 64'h30F0_7856_3412);
    run = 1'b0;
    tick();

    // Address wrap-around
    mem[8'hFE] = 8'h30; mem[8'hFF] = 8'hF0; mem[8'h00] = 8'hAA;
    mem[8'h01] = 8'hBB; mem[8'h02] = 8'hCC; mem[8'h03] = 8'hDD;
    apply_reset(32'hFFFF_FFFE);
    base = hs_addr.size();
    run = 1'b1;
    wait_step(20, n);
    check("wrap_instr", 64'(InstrBytes), 64'h30F0_AABB_CCDD);
    check("wrap_hs", 64'(hs_addr.size() - base), 64'd6);
    check("wrap_a1", 64'(hs_addr[base+1]), 64'hFFFF_FFFF);
    check("wrap_a2", 64'(hs_addr[base+2]), 64'h0);
    check("wrap_a5", 64'(hs_addr[base+5]), 64'h3);
    run = 1'b0;
    tick();
    check("wrap_pc", 64'(pc), 64'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
